ex_mem_stage: RTL

EX/MEM pipeline register plus data-memory access controller, directly downstream of the ID/EX register and the ALU. Captures EX-stage results and MEM/WB controls, issues one registered load/store request to the data memory, and waits on its busywait. Raises STALL_OUT to freeze the upstream registers, including the ID/EX BUSY_WAIT input, until the access completes. Also delivers aligned, sign/zero-extended load data to the MEM/WB register.

---
 rtl/ex_mem_stage_pkg.sv | 45 ++++
 rtl/ex_mem_stage_load_store_align.sv | 56 +++++
 rtl/ex_mem_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// ex_mem_stage_pkg : load/store encodings, FSM states, alignment helpers
// Rev 1.0
// ============================================================================
package ex_mem_stage_pkg;

    localparam logic [2:0] MEM_NONE = 3'd0;
    localparam logic [2:0] LB       = 3'd1;
    localparam logic [2:0] LH       = 3'd2;
    localparam logic [2:0] LW       = 3'd3;
    localparam logic [2:0] LBU      = 3'd4;
    localparam logic [2:0] LHU      = 3'd5;
    localparam logic [2:0] SB       = 3'd1;
    localparam logic [2:0] SH       = 3'd2;
    localparam logic [2:0] SW       = 3'd3;

    localparam logic [31:0] C_PC_RESET = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic is_load(input logic [2:0] t);
        return (t >= LB) && (t <= LHU);
    endfunction

    function automatic logic is_store(input logic [2:0] t);
        return (t >= SB) && (t <= SW);
    endfunction

    // A valid load takes precedence, so only its alignment matters when both are set.
    function automatic logic is_misaligned(input logic [2:0] ld, input logic [2:0] st,
                                           input logic [1:0] off);
        if (is_load(ld))
            return ((ld == LH || ld == LHU) && off[0]) || (ld == LW && off != 2'd0);
        else if (is_store(st))
            return (st == SH && off[0]) || (st == SW && off != 2'd0);
        else
            return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_load_store_align.sv
`default_nettype none
// ============================================================================
// load_store_align : store lane replication / byte enables and load extraction
// Rev 1.0
// ============================================================================
module load_store_align
    import ex_mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [2:0]  st_type,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = rdata >> {offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata   = store_data;
        byte_en = 4'b0000;
        case (st_type)
            SB: begin
                wdata   = {4{store_data[7:0]}};
                byte_en = 4'b0001 << offset;
            end
            SH: begin
                wdata   = {2{store_data[15:0]}};
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
            end
            SW: byte_en = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (ld_type)
            LB:      load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     load_data = {24'd0, w_byte};
            LH:      load_data = {{16{w_half[15]}}, w_half};
            LHU:     load_data = {16'd0, w_half};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// ex_mem_stage : EX/MEM pipeline register with stalling data-memory access FSM
// Optional macro MISALIGN_TRAP_EN adds the MISALIGNED output. Rev 1.0
// ============================================================================
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              REG_WRITE,
    input  logic [1:0]        MEM_TO_REG,
    input  logic [2:0]        MEM_READ,
    input  logic [2:0]        MEM_WRITE,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic [DATA_W-1:0] STORE_DATA,
    input  logic [DATA_W-1:0] PC_INCREMENT4,
    input  logic [REG_AW-1:0] RD,
    input  logic              DMEM_BUSYWAIT,
    input  logic [31:0]       DMEM_RDATA,
    output logic              DMEM_READ,
    output logic              DMEM_WRITE,
    output logic [31:0]       DMEM_ADDR,
    output logic [31:0]       DMEM_WDATA,
    output logic [3:0]        DMEM_BYTE_EN,
    output logic              STALL_OUT,
    output logic              REG_WRITE_OUT,
    output logic [1:0]        MEM_TO_REG_OUT,
    output logic [DATA_W-1:0] ALU_RESULT_OUT,
    output logic [DATA_W-1:0] PC_INCREMENT4_OUT,
    output logic [REG_AW-1:0] RD_OUT,
`ifdef MISALIGN_TRAP_EN
    output logic              MISALIGNED,
`endif
    output logic [DATA_W-1:0] LOAD_DATA_OUT
);

    state_t            r_state;
    logic              r_reg_write;
    logic [1:0]        r_mem_to_reg;
    logic [2:0]        r_mem_read;
    logic [2:0]        r_mem_write;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_store_data;
    logic [DATA_W-1:0] r_pc4;
    logic [REG_AW-1:0] r_rd;
    logic              r_dmem_read;
    logic              r_dmem_write;
    logic [DATA_W-1:0] r_load_data;
    logic              r_misaligned;

    logic [2:0]  w_cap_read;
    logic [2:0]  w_cap_write;
    logic        w_rd_valid;
    logic        w_wr_valid;
    logic        w_mis;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_load_data;

    assign w_cap_read  = FLUSH ? MEM_NONE : MEM_READ;
    assign w_cap_write = FLUSH ? MEM_NONE : MEM_WRITE;
    assign w_rd_valid  = is_load(w_cap_read);
    assign w_wr_valid  = is_store(w_cap_write);

`ifdef MISALIGN_TRAP_EN
    assign w_mis      = is_misaligned(w_cap_read, w_cap_write, ALU_RESULT[1:0]);
    assign MISALIGNED = r_misaligned;
`else
    assign w_mis = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= ST_IDLE;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 2'd0;
            r_mem_read   <= MEM_NONE;
            r_mem_write  <= MEM_NONE;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_pc4        <= DATA_W'(C_PC_RESET);
            r_rd         <= '0;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_reg_write  <= FLUSH ? 1'b0 : (REG_WRITE & ~w_mis);
                    r_mem_to_reg <= FLUSH ? 2'd0 : MEM_TO_REG;
                    r_mem_read   <= w_cap_read;
                    r_mem_write  <= w_cap_write;
                    r_alu_result <= ALU_RESULT;
                    r_store_data <= STORE_DATA;
                    r_pc4        <= PC_INCREMENT4;
                    r_rd         <= FLUSH ? '0 : RD;
                    r_misaligned <= w_mis;
                    r_dmem_read  <= w_rd_valid & ~w_mis;
                    r_dmem_write <= ~w_rd_valid & w_wr_valid & ~w_mis;
                    if ((w_rd_valid || w_wr_valid) && !w_mis)
                        r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!DMEM_BUSYWAIT) begin
                        if (r_dmem_read)
                            r_load_data <= DATA_W'(w_load_data);
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    load_store_align u_align (
        .ld_type    (r_mem_read),
        .st_type    (r_mem_write),
        .offset     (r_alu_result[1:0]),
        .store_data (r_store_data[31:0]),
        .rdata      (DMEM_RDATA),
        .wdata      (w_wdata),
        .byte_en    (w_be),
        .load_data  (w_load_data)
    );

    assign DMEM_READ         = r_dmem_read;
    assign DMEM_WRITE        = r_dmem_write;
    assign DMEM_ADDR         = {r_alu_result[31:2], 2'b00};
    assign DMEM_WDATA        = w_wdata;
    assign DMEM_BYTE_EN      = r_dmem_write ? w_be : 4'b0000;
    assign STALL_OUT         = (r_state == ST_ACCESS);
    assign REG_WRITE_OUT     = r_reg_write;
    assign MEM_TO_REG_OUT    = r_mem_to_reg;
    assign ALU_RESULT_OUT    = r_alu_result;
    assign PC_INCREMENT4_OUT = r_pc4;
    assign RD_OUT            = r_rd;
    assign LOAD_DATA_OUT     = r_load_data;

endmodule
`default_nettype wire
